// File: rtl/core_pkg.sv
// Shared core types and constants: data width, bubble instruction, reset PC,
// fetch FSM states and the IF/ID pipeline register layout.
package core_pkg;
  localparam int DW = 32;
  localparam logic [DW-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [DW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] inc_pc;
    logic          valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Hazard/redirect controls, instruction-ROM port and decode-side outputs of
// the fetch stage.
interface fetch_stage_if;
  logic                   stall_i;
  logic                   flush_i;
  logic                   redirect_i;
  logic [core_pkg::DW-1:0] redirect_pc_i;
  logic [core_pkg::DW-1:0] imem_addr_o;
  logic [core_pkg::DW-1:0] imem_rd_i;
  logic [core_pkg::DW-1:0] instrD_o;
  logic [core_pkg::DW-1:0] PCD_o;
  logic [core_pkg::DW-1:0] incPCD_o;
  logic                   validD_o;
  logic                   misaligned_o;
  logic [31:0]            fetch_count_o;

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rd_i,
    output imem_addr_o, instrD_o, PCD_o, incPCD_o, validD_o,
           misaligned_o, fetch_count_o
  );

  modport master (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rd_i,
    input  imem_addr_o, instrD_o, PCD_o, incPCD_o, validD_o,
           misaligned_o, fetch_count_o
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter register with load enable; async active-low reset to RESET_PC.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ROM address, IF/ID register, RUN/HALT FSM and fetch counter.
// One-cycle fetch latency; stall freezes PC and IF/ID, redirect/flush insert a bubble.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [DW-1:0] NOP      = NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  localparam if_id_t BUBBLE = '{instr: NOP, pc: '0, inc_pc: '0, valid: 1'b0};

  fetch_state_t  state, state_next;
  if_id_t        dec, dec_d;
  logic          dec_en;
  logic [DW-1:0] pc, pc_d, pc_plus4;
  logic          pc_en;
  logic          mis, mis_set;
  logic [31:0]   cnt;
  logic          cnt_en;

  assign pc_plus4 = pc + DW'(4);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    pc_d       = pc_plus4;
    dec_en     = 1'b0;
    dec_d      = BUBBLE;
    cnt_en     = 1'b0;
    mis_set    = 1'b0;
    case (state)
      RUN: begin
        if (bus.redirect_i) begin
          dec_en = 1'b1;
          if (bus.redirect_pc_i[1:0] == 2'b00) begin
            pc_en = 1'b1;
            pc_d  = bus.redirect_pc_i;
          end else begin
            mis_set    = 1'b1;
            state_next = HALT;
          end
        end else if (bus.flush_i) begin
          dec_en = 1'b1;
          pc_en  = !bus.stall_i;
        end else if (!bus.stall_i) begin
          pc_en  = 1'b1;
          dec_en = 1'b1;
          dec_d  = '{instr: bus.imem_rd_i, pc: pc, inc_pc: pc_plus4, valid: 1'b1};
          cnt_en = 1'b1;
        end
      end
      // Halted on a misaligned target: keep emitting bubbles until reset.
      HALT: dec_en = 1'b1;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      dec   <= BUBBLE;
      mis   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (dec_en)  dec <= dec_d;
      if (mis_set) mis <= 1'b1;
      if (cnt_en)  cnt <= cnt + 32'd1;
    end
  end

  assign bus.imem_addr_o   = pc;
  assign bus.instrD_o      = dec.instr;
  assign bus.PCD_o         = dec.pc;
  assign bus.incPCD_o      = dec.inc_pc;
  assign bus.validD_o      = dec.valid;
  assign bus.misaligned_o  = mis;
  assign bus.fetch_count_o = cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (normal and wrap-around reset PC).
module tb_fetch_stage;
  logic clk;
  logic rst0, rst1;
  int   n_cmp, n_err;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)) u0 (
    .clk (clk), .rst (rst0), .bus (bus0)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(32'h0000_0013)) u1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h0050_0093;
      32'h0000_0004: rom = 32'h0010_0113;
      default:       rom = 32'hC000_0000 ^ a;
    endcase
  endfunction

  assign bus0.imem_rd_i = rom(bus0.imem_addr_o);
  assign bus1.imem_rd_i = rom(bus1.imem_addr_o);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.stall_i = 0; bus0.flush_i = 0; bus0.redirect_i = 0; bus0.redirect_pc_i = '0;
    bus1.stall_i = 0; bus1.flush_i = 0; bus1.redirect_i = 0; bus1.redirect_pc_i = '0;
    step(); step();
    n_cmp++; if (bus0.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp %h", bus0.imem_addr_o, 32'h0); end
    n_cmp++; if (bus0.instrD_o !== 32'h13) begin n_err++; $display("FAIL rst_instr got %h exp %h", bus0.instrD_o, 32'h13); end
    n_cmp++; if (bus0.PCD_o !== 32'h0) begin n_err++; $display("FAIL rst_pcd got %h exp %h", bus0.PCD_o, 32'h0); end
    n_cmp++; if (bus0.incPCD_o !== 32'h0) begin n_err++; $display("FAIL rst_incpcd got %h exp %h", bus0.incPCD_o, 32'h0); end
    n_cmp++; if (bus0.validD_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", bus0.validD_o); end
    n_cmp++; if (bus0.misaligned_o !== 1'b0) begin n_err++; $display("FAIL rst_mis got %b exp 0", bus0.misaligned_o); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus0.fetch_count_o); end
    n_cmp++; if (bus1.imem_addr_o !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_addr_u1 got %h exp %h", bus1.imem_addr_o, 32'hFFFF_FFF8); end
  endtask

  task automatic test_sequential();
    rst0 = 1'b1;
    step();
    n_cmp++; if (bus0.instrD_o !== 32'h0050_0093) begin n_err++; $display("FAIL seq1_instr got %h exp %h", bus0.instrD_o, 32'h0050_0093); end
    n_cmp++; if (bus0.PCD_o !== 32'h0) begin n_err++; $display("FAIL seq1_pcd got %h exp %h", bus0.PCD_o, 32'h0); end
    n_cmp++; if (bus0.incPCD_o !== 32'h4) begin n_err++; $display("FAIL seq1_incpcd got %h exp %h", bus0.incPCD_o, 32'h4); end
    n_cmp++; if (bus0.validD_o !== 1'b1) begin n_err++; $display("FAIL seq1_valid got %b exp 1", bus0.validD_o); end
    n_cmp++; if (bus0.imem_addr_o !== 32'h4) begin n_err++; $display("FAIL seq1_addr got %h exp %h", bus0.imem_addr_o, 32'h4); end
    step();
    n_cmp++; if (bus0.instrD_o !== 32'h0010_0113) begin n_err++; $display("FAIL seq2_instr got %h exp %h", bus0.instrD_o, 32'h0010_0113); end
    n_cmp++; if (bus0.PCD_o !== 32'h4) begin n_err++; $display("FAIL seq2_pcd got %h exp %h", bus0.PCD_o, 32'h4); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd2) begin n_err++; $display("FAIL seq2_count got %0d exp 2", bus0.fetch_count_o); end
  endtask

  task automatic test_stall();
    bus0.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus0.imem_addr_o !== 32'h8) begin n_err++; $display("FAIL stall_addr[%0d] got %h exp %h", i, bus0.imem_addr_o, 32'h8); end
      n_cmp++; if (bus0.PCD_o !== 32'h4) begin n_err++; $display("FAIL stall_pcd[%0d] got %h exp %h", i, bus0.PCD_o, 32'h4); end
      n_cmp++; if (bus0.instrD_o !== 32'h0010_0113) begin n_err++; $display("FAIL stall_instr[%0d] got %h exp %h", i, bus0.instrD_o, 32'h0010_0113); end
      n_cmp++; if (bus0.fetch_count_o !== 32'd2) begin n_err++; $display("FAIL stall_count[%0d] got %0d exp 2", i, bus0.fetch_count_o); end
    end
    bus0.stall_i = 1'b0;
    step();
    n_cmp++; if (bus0.PCD_o !== 32'h8) begin n_err++; $display("FAIL resume_pcd got %h exp %h", bus0.PCD_o, 32'h8); end
    n_cmp++; if (bus0.instrD_o !== 32'hC000_0008) begin n_err++; $display("FAIL resume_instr got %h exp %h", bus0.instrD_o, 32'hC000_0008); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd3) begin n_err++; $display("FAIL resume_count got %0d exp 3", bus0.fetch_count_o); end
  endtask

  task automatic test_redirect_priority();
    // PC is 0xC here; redirect must win over simultaneous stall and flush.
    bus0.stall_i = 1'b1; bus0.flush_i = 1'b1; bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h40;
    step();
    bus0.stall_i = 1'b0; bus0.flush_i = 1'b0; bus0.redirect_i = 1'b0;
    n_cmp++; if (bus0.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL redir_addr got %h exp %h", bus0.imem_addr_o, 32'h40); end
    n_cmp++; if (bus0.instrD_o !== 32'h13) begin n_err++; $display("FAIL redir_instr got %h exp %h", bus0.instrD_o, 32'h13); end
    n_cmp++; if (bus0.validD_o !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b exp 0", bus0.validD_o); end
    n_cmp++; if (bus0.PCD_o !== 32'h0) begin n_err++; $display("FAIL redir_pcd got %h exp %h", bus0.PCD_o, 32'h0); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd3) begin n_err++; $display("FAIL redir_count got %0d exp 3", bus0.fetch_count_o); end
    step();
    n_cmp++; if (bus0.PCD_o !== 32'h40) begin n_err++; $display("FAIL redir2_pcd got %h exp %h", bus0.PCD_o, 32'h40); end
    n_cmp++; if (bus0.validD_o !== 1'b1) begin n_err++; $display("FAIL redir2_valid got %b exp 1", bus0.validD_o); end
    n_cmp++; if (bus0.incPCD_o !== 32'h44) begin n_err++; $display("FAIL redir2_incpcd got %h exp %h", bus0.incPCD_o, 32'h44); end
  endtask

  task automatic test_flush();
    bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h10;
    step();
    bus0.redirect_i = 1'b0; bus0.flush_i = 1'b1;
    step();
    n_cmp++; if (bus0.validD_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", bus0.validD_o); end
    n_cmp++; if (bus0.instrD_o !== 32'h13) begin n_err++; $display("FAIL flush_instr got %h exp %h", bus0.instrD_o, 32'h13); end
    n_cmp++; if (bus0.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL flush_addr got %h exp %h", bus0.imem_addr_o, 32'h14); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd4) begin n_err++; $display("FAIL flush_count got %0d exp 4", bus0.fetch_count_o); end
    bus0.stall_i = 1'b1;
    step();
    bus0.stall_i = 1'b0; bus0.flush_i = 1'b0;
    n_cmp++; if (bus0.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL flushstall_addr got %h exp %h", bus0.imem_addr_o, 32'h14); end
  endtask

  task automatic test_misaligned();
    bus0.redirect_i = 1'b1; bus0.redirect_pc_i = 32'h42;
    step();
    n_cmp++; if (bus0.misaligned_o !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b exp 1", bus0.misaligned_o); end
    n_cmp++; if (bus0.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL mis_addr got %h exp %h", bus0.imem_addr_o, 32'h14); end
    n_cmp++; if (bus0.validD_o !== 1'b0) begin n_err++; $display("FAIL mis_valid got %b exp 0", bus0.validD_o); end
    bus0.redirect_pc_i = 32'h80;
    for (int i = 0; i < 10; i++) begin
      bus0.stall_i    = i[0];
      bus0.flush_i    = i[1];
      bus0.redirect_i = (i % 3 == 0);
      step();
      n_cmp++; if (bus0.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL halt_addr[%0d] got %h exp %h", i, bus0.imem_addr_o, 32'h14); end
      n_cmp++; if (bus0.validD_o !== 1'b0) begin n_err++; $display("FAIL halt_valid[%0d] got %b exp 0", i, bus0.validD_o); end
      n_cmp++; if (bus0.fetch_count_o !== 32'd4) begin n_err++; $display("FAIL halt_count[%0d] got %0d exp 4", i, bus0.fetch_count_o); end
      n_cmp++; if (bus0.misaligned_o !== 1'b1) begin n_err++; $display("FAIL halt_mis[%0d] got %b exp 1", i, bus0.misaligned_o); end
    end
    bus0.stall_i = 0; bus0.flush_i = 0; bus0.redirect_i = 0;
    #2 rst0 = 1'b0;
    #1;
    n_cmp++; if (bus0.misaligned_o !== 1'b0) begin n_err++; $display("FAIL halt_rst_mis got %b exp 0", bus0.misaligned_o); end
    n_cmp++; if (bus0.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL halt_rst_addr got %h exp %h", bus0.imem_addr_o, 32'h0); end
    n_cmp++; if (bus0.fetch_count_o !== 32'd0) begin n_err++; $display("FAIL halt_rst_count got %0d exp 0", bus0.fetch_count_o); end
    step();
    rst0 = 1'b1;
    step();
    n_cmp++; if (bus0.PCD_o !== 32'h0 || bus0.validD_o !== 1'b1) begin n_err++; $display("FAIL halt_resume got pcd %h valid %b exp pcd 0 valid 1", bus0.PCD_o, bus0.validD_o); end
    n_cmp++; if (bus0.instrD_o !== 32'h0050_0093) begin n_err++; $display("FAIL halt_resume_instr got %h exp %h", bus0.instrD_o, 32'h0050_0093); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcd [3];
    logic [31:0] exp_inc [3];
    exp_pcd[0] = 32'hFFFF_FFF8; exp_pcd[1] = 32'hFFFF_FFFC; exp_pcd[2] = 32'h0000_0000;
    exp_inc[0] = 32'hFFFF_FFFC; exp_inc[1] = 32'h0000_0000; exp_inc[2] = 32'h0000_0004;
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus1.PCD_o !== exp_pcd[i]) begin n_err++; $display("FAIL wrap_pcd[%0d] got %h exp %h", i, bus1.PCD_o, exp_pcd[i]); end
      n_cmp++; if (bus1.incPCD_o !== exp_inc[i]) begin n_err++; $display("FAIL wrap_inc[%0d] got %h exp %h", i, bus1.incPCD_o, exp_inc[i]); end
    end
    n_cmp++; if (bus1.fetch_count_o !== 32'd3) begin n_err++; $display("FAIL wrap_count got %0d exp 3", bus1.fetch_count_o); end
    n_cmp++; if (bus1.imem_addr_o !== 32'h4) begin n_err++; $display("FAIL wrap_addr got %h exp %h", bus1.imem_addr_o, 32'h4); end
    bus1.stall_i = 1'b1;
    #2 rst1 = 1'b0;
    #1;
    n_cmp++; if (bus1.imem_addr_o !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_rst_addr got %h exp %h", bus1.imem_addr_o, 32'hFFFF_FFF8); end
    n_cmp++; if (bus1.instrD_o !== 32'h13 || bus1.validD_o !== 1'b0) begin n_err++; $display("FAIL wrap_rst_dec got instr %h valid %b exp 13 0", bus1.instrD_o, bus1.validD_o); end
    n_cmp++; if (bus1.PCD_o !== 32'h0 || bus1.incPCD_o !== 32'h0) begin n_err++; $display("FAIL wrap_rst_pcd got %h/%h exp 0/0", bus1.PCD_o, bus1.incPCD_o); end
    n_cmp++; if (bus1.fetch_count_o !== 32'd0 || bus1.misaligned_o !== 1'b0) begin n_err++; $display("FAIL wrap_rst_cnt got %0d mis %b exp 0 0", bus1.fetch_count_o, bus1.misaligned_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_flush();
    test_misaligned();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
